hazard_stall_unit: RTL

//  Stall-side partner of the operand forwarding logic in the 5-stage MIPS pipeline.

---
 rtl/hazard_stall_unit.sv | 108 ++++++++++
 1 files changed

// File: rtl/hazard_stall_unit.sv
// Load-use / branch-operand stall detector for the 5-stage pipe; drives PC, IF/ID and ID/EX enables.
// Zero latency: enables are combinational from state + inputs; MemBusy freezes everything.
module hazard_stall_unit #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] IDRegRs,
   input  logic [REG_W-1:0] IDRegRt,
   input  logic             IDUseRs,
   input  logic             IDUseRt,
   input  logic             IDBranch,
   input  logic             EXRegWrite,
   input  logic             EXMemRead,
   input  logic [REG_W-1:0] EXRegDst,
   input  logic             MEMMemRead,
   input  logic [REG_W-1:0] MEMRegDst,
   input  logic             MemBusy,
   input  logic             BranchTaken,
   input  logic             StallClear,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             IDEXBubble,
   output logic             IFFlush,
   output logic [CNT_W-1:0] StallCount
);

   typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

   state_t     state, state_nxt;
   logic       remain, remain_nxt;
   logic       m_ex, m_mem;
   logic [1:0] need;

   always_comb begin
      m_ex  = (EXRegDst != '0) &&
              ((IDUseRs && (EXRegDst == IDRegRs)) || (IDUseRt && (EXRegDst == IDRegRt)));
      m_mem = (MEMRegDst != '0) &&
              ((IDUseRs && (MEMRegDst == IDRegRs)) || (IDUseRt && (MEMRegDst == IDRegRt)));
   end

   // A branch resolved in ID behind a load needs the load through MEM: two bubbles.
   always_comb begin
      need = 2'd0;
      if (IDBranch && EXMemRead && m_ex)
         need = 2'd2;
      else if ((!IDBranch && EXMemRead && m_ex) ||
               (IDBranch && EXRegWrite && !EXMemRead && m_ex) ||
               (IDBranch && MEMMemRead && m_mem))
         need = 2'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= RUN;
         remain     <= 1'b0;
         StallCount <= '0;
      end else begin
         state  <= state_nxt;
         remain <= remain_nxt;
         if (StallClear)
            StallCount <= '0;
         else if (IDEXBubble && (StallCount != '1))
            StallCount <= StallCount + CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt  = state;
      remain_nxt = remain;
      if (!MemBusy) begin
         case (state)
            RUN: begin
               if (need == 2'd2) begin
                  state_nxt  = STALL;
                  remain_nxt = 1'b1;
               end
            end
            STALL: begin
               remain_nxt = remain - 1'b1;
               if (remain_nxt == 1'b0)
                  state_nxt = RUN;
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   always_comb begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b0;
      IFFlush    = 1'b0;
      if (!rst_n) begin
         IDEXBubble = 1'b1;
      end else if (!MemBusy) begin
         if ((state == STALL) || (need != 2'd0)) begin
            IDEXBubble = 1'b1;
         end else begin
            PCWrite   = 1'b1;
            IFIDWrite = 1'b1;
            IFFlush   = BranchTaken;
         end
      end
   end

endmodule
